alu_ctrl_decode_stage: RTL and testbench

ALU_CTRL_DECODE_STAGE -- requirements
Module: alu_ctrl_decode_stage

---
 rtl/alu_ctrl_decode_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_ctrl_decode_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode_stage.sv
// rtl/alu_ctrl_decode_stage.sv - RV32I ALU-control decode stage with one registered output slot
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   flush              kills the registered bundle and blocks accept this cycle
//   instr, in_valid    instruction word and its valid; in_ready is the accept handshake
//   out_valid          registered bundle valid; out_ready is the downstream accept
//   alu_control        ALU operation code
//   alu_src_imm        1 selects imm as ALU operand b
//   imm                sign-extended immediate
//   rs1, rs2, rd       register indices
//   illegal            bundle holds an unsupported encoding
//   illegal_count      saturating count of accepted illegal instructions
module alu_ctrl_decode_stage #(
    parameter logic [3:0] ILLEGAL_ALU_CTRL = 4'b0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_control,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    logic [3:0]  d_alu;
    logic        d_src_imm;
    logic [31:0] d_imm;
    logic        d_illegal;
    logic        accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Start from the illegal bundle; each legal encoding overrides it.
    always_comb begin
        d_alu     = ILLEGAL_ALU_CTRL;
        d_src_imm = 1'b0;
        d_imm     = 32'd0;
        d_illegal = 1'b1;
        case (opcode)
            7'b0110011: begin
                d_illegal = 1'b0;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: d_alu = ALU_ADD;
                    {7'b0100000, 3'b000}: d_alu = ALU_SUB;
                    {7'b0000000, 3'b001}: d_alu = ALU_SLL;
                    {7'b0000000, 3'b010}: d_alu = ALU_SLT;
                    {7'b0000000, 3'b100}: d_alu = ALU_XOR;
                    {7'b0100000, 3'b101}: d_alu = ALU_SRA;
                    {7'b0000000, 3'b110}: d_alu = ALU_OR;
                    {7'b0000000, 3'b111}: d_alu = ALU_AND;
                    default: begin
                        d_alu     = ILLEGAL_ALU_CTRL;
                        d_illegal = 1'b1;
                    end
                endcase
            end
            7'b0010011: begin
                d_illegal = 1'b0;
                d_src_imm = 1'b1;
                d_imm     = imm_i;
                case (funct3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: if (funct7 == 7'b0000000) d_alu = ALU_SLL;
                            else d_illegal = 1'b1;
                    3'b101: if (funct7 == 7'b0100000) d_alu = ALU_SRA;
                            else d_illegal = 1'b1;
                    default: d_illegal = 1'b1;
                endcase
                // A rejected shift encoding must not leak its immediate.
                if (d_illegal) begin
                    d_alu     = ILLEGAL_ALU_CTRL;
                    d_src_imm = 1'b0;
                    d_imm     = 32'd0;
                end
            end
            7'b0000011: if (funct3 == 3'b010) begin
                d_illegal = 1'b0;
                d_alu     = ALU_ADD;
                d_src_imm = 1'b1;
                d_imm     = imm_i;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                d_illegal = 1'b0;
                d_alu     = ALU_ADD;
                d_src_imm = 1'b1;
                d_imm     = imm_s;
            end
            7'b1100011: if (funct3 == 3'b000) begin
                d_illegal = 1'b0;
                d_alu     = ALU_SUB;
                d_imm     = imm_b;
            end
            default: ;
        endcase
    end

    // Reset also blocks accept, so in_ready is forced low while it is held.
    assign in_ready = !reset && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_control   <= ALU_ADD;
            alu_src_imm   <= 1'b0;
            imm           <= 32'd0;
            rs1           <= 5'd0;
            rs2           <= 5'd0;
            rd            <= 5'd0;
            illegal       <= 1'b0;
            illegal_count <= 8'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            alu_control <= d_alu;
            alu_src_imm <= d_src_imm;
            imm         <= d_imm;
            rs1         <= instr[19:15];
            rs2         <= instr[24:20];
            rd          <= instr[11:7];
            illegal     <= d_illegal;
            if (d_illegal && illegal_count != 8'hFF)
                illegal_count <= illegal_count + 8'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// tb/tb_alu_ctrl_decode_stage.sv - self-checking bench for alu_ctrl_decode_stage
module tb_alu_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic        in_ready, out_valid, alu_src_imm, illegal;
    logic [3:0]  alu_control;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctrl_decode_stage #(.ILLEGAL_ALU_CTRL(4'b0010)) dut (
        .clk(clk), .reset(reset), .flush(flush), .instr(instr),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .alu_control(alu_control), .alu_src_imm(alu_src_imm),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Legal-encoding table: kind 0 = register operand, 1 = I imm, 2 = S imm, 3 = B imm.
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        bit         f7_care;
        logic [6:0] f7;
        logic [3:0] alu;
        int         kind;
    } enc_t;
    enc_t tbl[$];

    // Reference state of the registered bundle.
    logic        m_valid, m_src, m_ill;
    logic [3:0]  m_alu;
    logic [31:0] m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_cnt;

    task automatic add_enc(input logic [6:0] op, input logic [2:0] f3, input bit care,
                           input logic [6:0] f7, input logic [3:0] alu, input int kind);
        enc_t e;
        e.op = op; e.f3 = f3; e.f7_care = care; e.f7 = f7; e.alu = alu; e.kind = kind;
        tbl.push_back(e);
    endtask

    task automatic ref_decode(input logic [31:0] w, output logic [3:0] alu, output logic src,
                              output logic [31:0] im, output logic ill);
        int v;
        alu = 4'b0010; src = 1'b0; im = 32'd0; ill = 1'b1;
        foreach (tbl[k]) begin
            if (w[6:0] == tbl[k].op && w[14:12] == tbl[k].f3 &&
                (!tbl[k].f7_care || w[31:25] == tbl[k].f7)) begin
                ill = 1'b0;
                alu = tbl[k].alu;
                src = (tbl[k].kind == 1 || tbl[k].kind == 2);
                case (tbl[k].kind)
                    1: v = $signed(w) >>> 20;
                    2: v = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
                    3: v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048
                           + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                    default: v = 0;
                endcase
                im = v;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("alu_control", {28'd0, alu_control}, {28'd0, m_alu});
        chk("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, m_src});
        chk("imm", imm, m_imm);
        chk("rs1", {27'd0, rs1}, {27'd0, m_rs1});
        chk("rs2", {27'd0, rs2}, {27'd0, m_rs2});
        chk("rd", {27'd0, rd}, {27'd0, m_rd});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("illegal_count", {24'd0, illegal_count}, m_cnt);
    endtask

    // One clock: drive, check in_ready, clock, advance model, check bundle.
    task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] w);
        logic       exp_ready;
        logic [3:0] a; logic s; logic [31:0] im; logic il;
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy; instr = w;
        #1;
        exp_ready = !rst && !fl && (!m_valid || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_alu = 4'b0010; m_src = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ill = 0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (iv && exp_ready) begin
            ref_decode(w, a, s, im, il);
            m_valid = 1; m_alu = a; m_src = s; m_imm = im; m_ill = il;
            m_rs1 = w[19:15]; m_rs2 = w[24:20]; m_rd = w[11:7];
            if (il && m_cnt < 255) m_cnt++;
        end else if (ordy) begin
            m_valid = 0;
        end
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: ;
            1: w = {7'b0000000, w[24:15], 3'b101, w[11:7], 7'b0110011}; // srl
            default: begin
                k = $urandom_range(0, tbl.size() - 1);
                w[6:0] = tbl[k].op;
                w[14:12] = tbl[k].f3;
                if (tbl[k].f7_care) w[31:25] = tbl[k].f7;
            end
        endcase
        return w;
    endfunction

    initial begin
        add_enc(7'b0110011, 3'b000, 1, 7'h00, 4'b0010, 0);
        add_enc(7'b0110011, 3'b000, 1, 7'h20, 4'b0110, 0);
        add_enc(7'b0110011, 3'b001, 1, 7'h00, 4'b0101, 0);
        add_enc(7'b0110011, 3'b010, 1, 7'h00, 4'b0111, 0);
        add_enc(7'b0110011, 3'b100, 1, 7'h00, 4'b0100, 0);
        add_enc(7'b0110011, 3'b101, 1, 7'h20, 4'b1101, 0);
        add_enc(7'b0110011, 3'b110, 1, 7'h00, 4'b0001, 0);
        add_enc(7'b0110011, 3'b111, 1, 7'h00, 4'b0000, 0);
        add_enc(7'b0010011, 3'b000, 0, 7'h00, 4'b0010, 1);
        add_enc(7'b0010011, 3'b010, 0, 7'h00, 4'b0111, 1);
        add_enc(7'b0010011, 3'b100, 0, 7'h00, 4'b0100, 1);
        add_enc(7'b0010011, 3'b110, 0, 7'h00, 4'b0001, 1);
        add_enc(7'b0010011, 3'b111, 0, 7'h00, 4'b0000, 1);
        add_enc(7'b0010011, 3'b001, 1, 7'h00, 4'b0101, 1);
        add_enc(7'b0010011, 3'b101, 1, 7'h20, 4'b1101, 1);
        add_enc(7'b0000011, 3'b010, 0, 7'h00, 4'b0010, 1);
        add_enc(7'b0100011, 3'b010, 0, 7'h00, 4'b0010, 2);
        add_enc(7'b1100011, 3'b000, 0, 7'h00, 4'b0110, 3);

        m_valid = 0; m_alu = 4'b0010; m_src = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ill = 0; m_cnt = 0;

        // Reset state, with an instruction offered that must be ignored.
        cycle(1, 0, 1, 1, 32'h002081B3);
        cycle(1, 1, 1, 1, 32'h00000000);

        // add x3,x1,x2 then known-value checks.
        cycle(0, 0, 1, 1, 32'h002081B3);
        chk("add_alu", {28'd0, alu_control}, 32'h2);
        chk("add_rs1_rs2_rd", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        cycle(0, 0, 1, 1, 32'h402081B3);
        chk("sub_alu", {28'd0, alu_control}, 32'h6);
        cycle(0, 0, 1, 1, 32'hFFF00293);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        cycle(0, 0, 1, 1, 32'h40335313);
        chk("srai_alu_imm", {alu_control, imm[27:0]}, {4'hD, 28'h0000403});
        cycle(0, 0, 0, 1, 32'h0);

        // Back-pressure for 5 cycles, then drain and load on the same edge.
        cycle(0, 0, 1, 1, 32'h002081B3);
        repeat (5) cycle(0, 0, 1, 0, 32'h402081B3);
        cycle(0, 0, 1, 1, 32'h402081B3);
        chk("drain_load", {27'd0, out_valid, alu_control}, {27'd0, 1'b1, 4'b0110});

        // Illegal counting and saturation.
        cycle(1, 0, 0, 1, 32'h0);
        cycle(0, 0, 1, 1, 32'h00000000);
        cycle(0, 0, 1, 1, 32'h0020D1B3);
        chk("illegal_count_2", {24'd0, illegal_count}, 32'd2);
        repeat (260) cycle(0, 0, 1, 1, 32'h00000000);
        chk("illegal_count_sat", {24'd0, illegal_count}, 32'd255);

        // Flush with a valid bundle held and an illegal offered.
        cycle(1, 0, 0, 1, 32'h0);
        repeat (7) cycle(0, 0, 1, 1, 32'h0020D1B3);
        cycle(0, 1, 1, 0, 32'h00000000);
        chk("flush_count", {24'd0, illegal_count}, 32'd7);

        // Reset with out_valid=1 and illegal_count=7.
        cycle(0, 0, 1, 1, 32'h002081B3);
        cycle(1, 0, 1, 0, 32'h00000000);
        chk("reset_clears", {23'd0, out_valid, illegal_count}, 32'd0);

        // Randomized traffic.
        repeat (400)
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), rand_instr());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
